// File: rtl/riscv_core_pkg.sv
// Shared types and constants for the RISC-V core front end: fetch FSM states,
// datapath widths and the instruction-memory geometry.
package riscv_core_pkg;

    localparam int XLEN       = 32;
    localparam int IMEM_DEPTH = 32;
    localparam int AW         = $clog2(IMEM_DEPTH);

    localparam logic [XLEN-1:0] RESET_PC   = 32'h0000_0000;
    localparam logic [XLEN-1:0] IMEM_BYTES = XLEN'(4 * IMEM_DEPTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FETCH = 3'd2,
        EXEC  = 3'd3,
        HALT  = 3'd4
    } fetch_state_t;

    // A PC is unusable when it is not word aligned or points past the last word.
    function automatic logic pc_fault(input logic [XLEN-1:0] pc);
        return (pc[1:0] != 2'b00) || (pc >= IMEM_BYTES);
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of loader, instruction-memory and execute-side signals of the fetch sequencer.
// master = the sequencer, slave = the surrounding loader/memory/datapath.
interface fetch_sequencer_if;
    import riscv_core_pkg::*;

    logic            boot_valid;
    logic            boot_ready;
    logic [XLEN-1:0] boot_data;
    logic            boot_last;
    logic            start;
    logic            imem_we;
    logic [AW-1:0]   imem_waddr;
    logic [XLEN-1:0] imem_wdata;
    logic            imem_re;
    logic [AW-1:0]   imem_raddr;
    logic [XLEN-1:0] instr_in;
    logic            instr_valid;
    logic [XLEN-1:0] instr_out;
    logic [XLEN-1:0] pc_out;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            halt_req;
    logic            halted;
    logic            err;

    modport master (
        input  boot_valid, boot_data, boot_last, start, instr_in,
               branch_taken, branch_target, halt_req,
        output boot_ready, imem_we, imem_waddr, imem_wdata, imem_re, imem_raddr,
               instr_valid, instr_out, pc_out, halted, err
    );

    modport slave (
        output boot_valid, boot_data, boot_last, start, instr_in,
               branch_taken, branch_target, halt_req,
        input  boot_ready, imem_we, imem_waddr, imem_wdata, imem_re, imem_raddr,
               instr_valid, instr_out, pc_out, halted, err
    );

endinterface

// File: rtl/fetch_sequencer_pc_next_sel.sv
// Next-PC selection after an issued instruction: halt > branch > sequential,
// plus the alignment/range check on the resulting PC.
module pc_next_sel
    import riscv_core_pkg::*;
(
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_halt_req,
    input  logic            i_branch_taken,
    input  logic [XLEN-1:0] i_branch_target,
    output logic [XLEN-1:0] o_next_pc,
    output logic            o_next_halt,
    output logic            o_next_err
);

    // Priority select; a halt keeps the current (already valid) PC unchecked.
    always_comb begin
        o_next_pc   = i_pc;
        o_next_halt = 1'b0;
        o_next_err  = 1'b0;
        if (i_halt_req) begin
            o_next_pc   = i_pc;
            o_next_halt = 1'b1;
        end else if (i_branch_taken) begin
            o_next_pc  = i_branch_target;
            o_next_err = pc_fault(i_branch_target);
        end else begin
            o_next_pc  = i_pc + 32'd4;
            o_next_err = pc_fault(i_pc + 32'd4);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: boots the program into instruction memory, then
// fetches and issues one instruction every two cycles until halted or faulted.
module fetch_sequencer
    import riscv_core_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    fetch_sequencer_if.master bus
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic [AW-1:0]   r_load_cnt;
    logic            r_err;
    logic            r_boot_ready;
    logic            r_imem_re;
    logic            r_instr_valid;
    logic            r_halted;

    logic            w_boot_fire;
    logic            w_load_full;
    logic [XLEN-1:0] w_next_pc;
    logic            w_next_halt;
    logic            w_next_err;

    pc_next_sel u_pc_next_sel (
        .i_pc            (r_pc),
        .i_halt_req      (bus.halt_req),
        .i_branch_taken  (bus.branch_taken),
        .i_branch_target (bus.branch_target),
        .o_next_pc       (w_next_pc),
        .o_next_halt     (w_next_halt),
        .o_next_err      (w_next_err)
    );

    assign w_boot_fire = r_boot_ready & bus.boot_valid;
    assign w_load_full = (r_load_cnt == AW'(IMEM_DEPTH - 1));

    // The write strobe follows the loader handshake in the same cycle.
    assign bus.boot_ready  = r_boot_ready;
    assign bus.imem_we     = w_boot_fire;
    assign bus.imem_waddr  = r_load_cnt;
    assign bus.imem_wdata  = w_boot_fire ? bus.boot_data : {XLEN{1'b0}};
    assign bus.imem_re     = r_imem_re;
    assign bus.imem_raddr  = r_imem_re ? r_pc[AW+1:2] : {AW{1'b0}};
    assign bus.instr_valid = r_instr_valid;
    assign bus.instr_out   = r_instr_valid ? bus.instr_in : {XLEN{1'b0}};
    assign bus.pc_out      = r_instr_valid ? r_pc : {XLEN{1'b0}};
    assign bus.halted      = r_halted;
    assign bus.err         = r_err;

    // Sequencer FSM with PC, load counter, sticky error and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_load_cnt    <= {AW{1'b0}};
            r_err         <= 1'b0;
            r_boot_ready  <= 1'b0;
            r_imem_re     <= 1'b0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.boot_valid) begin
                        r_state      <= LOAD;
                        r_boot_ready <= 1'b1;
                    end else if (bus.start) begin
                        r_state   <= FETCH;
                        r_pc      <= RESET_PC;
                        r_err     <= 1'b0;
                        r_imem_re <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                LOAD: begin
                    // Writing the last index without boot_last is an overflow; no wrap.
                    if (w_boot_fire && (bus.boot_last || w_load_full)) begin
                        r_state      <= IDLE;
                        r_boot_ready <= 1'b0;
                        r_load_cnt   <= {AW{1'b0}};
                        r_err        <= r_err | ~bus.boot_last;
                    end else if (w_boot_fire) begin
                        r_load_cnt <= r_load_cnt + AW'(1);
                    end else begin
                        r_state <= LOAD;
                    end
                end
                FETCH: begin
                    r_state       <= EXEC;
                    r_imem_re     <= 1'b0;
                    r_instr_valid <= 1'b1;
                end
                EXEC: begin
                    r_instr_valid <= 1'b0;
                    r_pc          <= w_next_pc;
                    if (w_next_halt || w_next_err) begin
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                        r_err    <= r_err | w_next_err;
                    end else begin
                        r_state   <= FETCH;
                        r_imem_re <= 1'b1;
                    end
                end
                HALT: begin
                    if (bus.start) begin
                        r_state   <= FETCH;
                        r_pc      <= RESET_PC;
                        r_err     <= 1'b0;
                        r_halted  <= 1'b0;
                        r_imem_re <= 1'b1;
                    end else if (bus.boot_valid) begin
                        r_state      <= LOAD;
                        r_halted     <= 1'b0;
                        r_boot_ready <= 1'b1;
                    end else begin
                        r_state <= HALT;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_boot_ready  <= 1'b0;
                    r_imem_re     <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_halted      <= 1'b0;
                    r_load_cnt    <= {AW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed boot/run/fault/reset scenarios
// plus randomized branch/halt runs checked against an address-level program model.
module tb_fetch_sequencer;
    import riscv_core_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_sequencer_if bus ();

    fetch_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem     [32];
    logic [31:0] exp_mem [32];
    logic [31:0] prog    [33];
    int n_checks = 0;
    int n_errors = 0;
    int unsigned act_q[$];
    logic [31:0] tgt_q[$];

    // Synchronous instruction memory with one-cycle read latency.
    always @(posedge clk) begin
        if (bus.imem_we) mem[bus.imem_waddr] <= bus.imem_wdata;
        if (bus.imem_re) bus.instr_in <= mem[bus.imem_raddr];
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.boot_valid    = 1'b0;
        bus.boot_data     = 32'd0;
        bus.boot_last     = 1'b0;
        bus.start         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'd0;
        bus.halt_req      = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_boot_ready"}, 32'(bus.boot_ready), 32'd0);
        check_val({tag, "_we"},         32'(bus.imem_we), 32'd0);
        check_val({tag, "_re"},         32'(bus.imem_re), 32'd0);
        check_val({tag, "_valid"},      32'(bus.instr_valid), 32'd0);
        check_val({tag, "_halted"},     32'(bus.halted), 32'd0);
        check_val({tag, "_err"},        32'(bus.err), 32'd0);
        check_val({tag, "_pc_out"},     bus.pc_out, 32'd0);
        check_val({tag, "_instr_out"},  bus.instr_out, 32'd0);
        check_val({tag, "_waddr"},      32'(bus.imem_waddr), 32'd0);
        check_val({tag, "_wdata"},      bus.imem_wdata, 32'd0);
        check_val({tag, "_raddr"},      32'(bus.imem_raddr), 32'd0);
    endtask

    // Offer prog[0..n-1] to the loader; each accepted word must hit the next index.
    task automatic load_words(input int n, input bit with_last);
        int i = 0;
        int cyc = 0;
        while (i < n && cyc < 4 * n + 8) begin
            @(negedge clk);
            bus.boot_valid = 1'b1;
            bus.boot_data  = prog[i];
            bus.boot_last  = with_last && (i == n - 1);
            #1;
            check_val("load_excl", 32'(bus.imem_we & bus.imem_re), 32'd0);
            if (bus.boot_ready) begin
                check_val("load_we", 32'(bus.imem_we), 32'd1);
                check_val("load_waddr", 32'(bus.imem_waddr), 32'(i));
                check_val("load_wdata", bus.imem_wdata, prog[i]);
                exp_mem[i] = prog[i];
                i++;
            end else begin
                check_val("load_we_wait", 32'(bus.imem_we), 32'd0);
            end
            cyc++;
        end
        check_val("load_count", 32'(i), 32'(n));
        @(negedge clk);
        bus.boot_valid = 1'b0;
        bus.boot_last  = 1'b0;
        #1;
        if (with_last) check_val("load_done_ready", 32'(bus.boot_ready), 32'd0);
    endtask

    // Start the core and follow it issue by issue. Actions come from act_q/tgt_q
    // (0 seq, 1 halt, 2 branch, 3 halt+branch) or are drawn at random.
    task automatic run_prog(input int max_issue, input bit also_boot);
        logic [31:0] pc_m;
        logic [31:0] nxt;
        logic [31:0] tgt;
        int unsigned act;
        int r;
        int n = 0;
        bit done = 1'b0;
        bit fault = 1'b0;
        @(negedge clk);
        bus.start      = 1'b1;
        bus.boot_valid = also_boot;
        bus.boot_data  = 32'hDEAD_BEEF;
        #1;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.boot_valid = 1'b0;
        #1;
        pc_m = RESET_PC;
        check_val("fetch0_re", 32'(bus.imem_re), 32'd1);
        check_val("fetch0_raddr", 32'(bus.imem_raddr), pc_m >> 2);
        check_val("start_err_clr", 32'(bus.err), 32'd0);
        check_val("fetch0_ready", 32'(bus.boot_ready), 32'd0);
        check_val("fetch0_halted", 32'(bus.halted), 32'd0);
        while (!done) begin
            @(negedge clk);
            bus.halt_req     = 1'b0;
            bus.branch_taken = 1'b0;
            #1;
            check_val("exec_valid", 32'(bus.instr_valid), 32'd1);
            check_val("exec_pc", bus.pc_out, pc_m);
            check_val("exec_instr", bus.instr_out, exp_mem[pc_m[6:2]]);
            check_val("exec_we", 32'(bus.imem_we), 32'd0);
            check_val("exec_re", 32'(bus.imem_re), 32'd0);
            if (act_q.size() > 0) begin
                act = act_q.pop_front();
                tgt = tgt_q.pop_front();
            end else begin
                r   = $urandom_range(0, 99);
                act = (n >= max_issue || r < 8) ? 1 : (r < 12) ? 3 : (r < 45) ? 2 : 0;
                if ($urandom_range(0, 9) == 0) tgt = 32'($urandom_range(0, 255));
                else tgt = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
            end
            bus.halt_req      = (act == 1 || act == 3);
            bus.branch_taken  = (act >= 2);
            bus.branch_target = tgt;
            n++;
            if (act == 1 || act == 3) begin
                done  = 1'b1;
                fault = 1'b0;
            end else begin
                nxt   = (act == 2) ? tgt : pc_m + 32'd4;
                fault = (nxt % 4 != 0) || (nxt >= 32'd128);
                pc_m  = nxt;
                done  = fault;
            end
            if (!done) begin
                @(negedge clk);
                bus.halt_req     = 1'b0;
                bus.branch_taken = 1'b0;
                #1;
                check_val("fetch_re", 32'(bus.imem_re), 32'd1);
                check_val("fetch_raddr", 32'(bus.imem_raddr), pc_m >> 2);
                check_val("fetch_valid", 32'(bus.instr_valid), 32'd0);
            end
        end
        @(negedge clk);
        bus.halt_req     = 1'b0;
        bus.branch_taken = 1'b0;
        #1;
        check_val("halted", 32'(bus.halted), 32'd1);
        check_val("halt_err", 32'(bus.err), 32'(fault));
        check_val("halt_valid", 32'(bus.instr_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d errors so far", n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_zero("rst_rel");

        // Full image, boot_last on the final index is not an overflow.
        for (int i = 0; i < 32; i++) prog[i] = $urandom;
        load_words(32, 1'b1);
        check_val("full_load_err", 32'(bus.err), 32'd0);

        prog[0] = 32'h0000_0013;
        prog[1] = 32'h0050_0093;
        prog[2] = 32'h0010_0073;
        load_words(3, 1'b1);
        check_val("load3_err", 32'(bus.err), 32'd0);

        act_q = '{0, 0, 1};           tgt_q = '{32'd0, 32'd0, 32'd0};
        run_prog(40, 1'b0);
        act_q = '{0, 2, 3};           tgt_q = '{32'd0, 32'h10, 32'h40};
        run_prog(40, 1'b0);
        act_q = '{2};                 tgt_q = '{32'h6};
        run_prog(40, 1'b0);
        act_q = '{2, 0};              tgt_q = '{32'h7C, 32'd0};
        run_prog(40, 1'b0);
        act_q = '{0, 1};              tgt_q = '{32'd0, 32'd0};
        run_prog(40, 1'b1);

        repeat (25) run_prog(30, 1'b0);

        // Reload from HALT, then run again on the new image.
        for (int i = 0; i < 5; i++) prog[i] = $urandom;
        load_words(5, 1'b1);
        repeat (5) run_prog(30, 1'b0);

        // Overflow: 32 words without boot_last.
        for (int i = 0; i < 33; i++) prog[i] = $urandom;
        load_words(32, 1'b0);
        check_val("ovf_state_ready", 32'(bus.boot_ready), 32'd0);
        check_val("ovf_err", 32'(bus.err), 32'd1);
        @(negedge clk);
        bus.boot_valid = 1'b1;
        bus.boot_data  = prog[32];
        #1;
        check_val("ovf33_ready", 32'(bus.boot_ready), 32'd0);
        check_val("ovf33_we", 32'(bus.imem_we), 32'd0);
        @(negedge clk);
        bus.boot_valid = 1'b0;

        // Two words of a transfer, then asynchronous reset mid-LOAD.
        prog[0] = 32'h1111_1111;
        prog[1] = 32'h2222_2222;
        load_words(2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("rst_load");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_zero("rst_load_rel");
        prog[0] = 32'h0000_0013;
        load_words(1, 1'b1);

        // Asynchronous reset while an instruction is being issued.
        @(negedge clk);
        bus.start = 1'b1;
        #1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #1;
        check_val("rst_exec_pre_valid", 32'(bus.instr_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("rst_exec");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_zero("rst_exec_rel");
        act_q = '{0, 1};  tgt_q = '{32'd0, 32'd0};
        run_prog(40, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
